// File: rtl/scoreboard_hazard.sv
// Register scoreboard with per-register latency down-counters and a multi-cycle
// unit occupancy counter. It produces per-stage stall/flush controls for a pipeline.
module scoreboard_hazard #(
    parameter  int NREG     = 32,
    parameter  int NSRC     = 2,
    parameter  int ALU_LAT  = 1,
    parameter  int LOAD_LAT = 2,
    parameter  int MUL_LAT  = 4,
    localparam int ADDR_W   = $clog2(NREG),
    localparam int MAX_LAT  = (ALU_LAT > LOAD_LAT)
                              ? ((ALU_LAT > MUL_LAT) ? ALU_LAT : MUL_LAT)
                              : ((LOAD_LAT > MUL_LAT) ? LOAD_LAT : MUL_LAT),
    localparam int CNT_W    = $clog2(MAX_LAT + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   d_valid,
    input  logic [NSRC*ADDR_W-1:0] rs,
    input  logic [NSRC-1:0]        src_en,
    input  logic [ADDR_W-1:0]      rd,
    input  logic                   wr,
    input  logic [1:0]             op_class,
    input  logic                   ebranch,
    input  logic                   i_wait,
    input  logic                   d_wait,
    output logic                   stallF,
    output logic                   stallD,
    output logic                   stallE,
    output logic                   stallM,
    output logic                   flushF,
    output logic                   flushD,
    output logic                   flushE,
    output logic                   flushM,
    output logic                   mul_busy,
    output logic [NREG-1:0]        pending
);

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_ALU  = 2'd1,
        OP_LOAD = 2'd2,
        OP_MUL  = 2'd3
    } op_e;

    logic [CNT_W-1:0]  cnt [NREG];
    logic [CNT_W-1:0]  busy;
    op_e               op;
    logic [CNT_W-1:0]  lat_d;
    logic [ADDR_W-1:0] src_addr;
    logic              raw_haz;
    logic              waw_haz;
    logic              str_haz;
    logic              haz;
    logic              issue;
    logic              freeze;
    logic              load_rd;

    assign op = op_e'(op_class);

    always_comb begin
        lat_d = '0;
        unique case (op)
            OP_ALU:  lat_d = CNT_W'(ALU_LAT);
            OP_LOAD: lat_d = CNT_W'(LOAD_LAT);
            OP_MUL:  lat_d = CNT_W'(MUL_LAT);
            default: lat_d = '0;
        endcase
    end

    always_comb begin
        raw_haz  = 1'b0;
        src_addr = '0;
        for (int unsigned j = 0; j < NSRC; j++) begin
            src_addr = rs[j*ADDR_W +: ADDR_W];
            if (src_en[j] && (src_addr != '0) && (cnt[src_addr] != '0))
                raw_haz = 1'b1;
        end
    end

    // A younger write may not retire before an older one still in flight.
    assign waw_haz = wr && (rd != '0) && (op != OP_NONE) && (cnt[rd] > lat_d);
    assign str_haz = (op == OP_MUL) && (busy != '0);
    assign haz     = d_valid && (raw_haz || waw_haz || str_haz);
    assign issue   = d_valid && !d_wait && !ebranch && !haz;
    assign freeze  = d_wait || (ebranch && i_wait);
    assign load_rd = issue && wr && (rd != '0) && (op != OP_NONE);

    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        flushF = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        flushM = 1'b0;
        if (d_wait) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            flushM = 1'b1;
        end else if (ebranch && i_wait) begin
            stallF = 1'b1;
            stallE = 1'b1;
            flushD = 1'b1;
        end else if (ebranch) begin
            flushF = 1'b1;
            flushD = 1'b1;
        end else if (haz) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end else if (i_wait) begin
            stallF = 1'b1;
        end
    end

    // Entry 0 is only ever cleared, so it always reads as not pending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++)
                cnt[i] <= '0;
            busy <= '0;
        end else if (!freeze) begin
            for (int unsigned i = 1; i < NREG; i++)
                cnt[i] <= (cnt[i] != '0) ? cnt[i] - CNT_W'(1) : '0;
            if (load_rd)
                cnt[rd] <= lat_d;
            if (issue && (op == OP_MUL))
                busy <= CNT_W'(MUL_LAT);
            else
                busy <= (busy != '0) ? busy - CNT_W'(1) : '0;
        end
    end

    assign mul_busy = (busy != '0);

    always_comb begin
        pending = '0;
        for (int unsigned i = 0; i < NREG; i++)
            pending[i] = (cnt[i] != '0);
    end

endmodule

// File: tb/tb_scoreboard_hazard.sv
// Directed bench for scoreboard_hazard: a sequential vector table followed by
// hand-written multi-cycle sequences (structural, WAW, data-wait freeze, reset).
module tb_scoreboard_hazard;

    logic        clk;
    logic        reset;
    logic        d_valid;
    logic [9:0]  rs;
    logic [1:0]  src_en;
    logic [4:0]  rd;
    logic        wr;
    logic [1:0]  op_class;
    logic        ebranch;
    logic        i_wait;
    logic        d_wait;
    logic        stallF, stallD, stallE, stallM;
    logic        flushF, flushD, flushE, flushM;
    logic        mul_busy;
    logic [31:0] pending;
    logic [7:0]  ctrl;

    int unsigned total;
    int unsigned passed;

    scoreboard_hazard #(
        .NREG(32), .NSRC(2), .ALU_LAT(1), .LOAD_LAT(2), .MUL_LAT(4)
    ) dut (
        .clk(clk), .reset(reset), .d_valid(d_valid), .rs(rs), .src_en(src_en),
        .rd(rd), .wr(wr), .op_class(op_class), .ebranch(ebranch),
        .i_wait(i_wait), .d_wait(d_wait),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushF(flushF), .flushD(flushD), .flushE(flushE), .flushM(flushM),
        .mul_busy(mul_busy), .pending(pending)
    );

    assign ctrl = {stallF, stallD, stallE, stallM, flushF, flushD, flushE, flushM};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1);
    end

    typedef struct {
        logic        dv;
        logic [4:0]  r1;
        logic [4:0]  r0;
        logic [1:0]  se;
        logic [4:0]  d;
        logic        w;
        logic [1:0]  op;
        logic        eb;
        logic        iw;
        logic        dw;
        logic [7:0]  ctrl;
        logic        mb;
        logic [31:0] pend;
    } vec_t;

    vec_t tbl [20];

    task automatic set_in(input logic dv, input logic [4:0] r1, input logic [4:0] r0,
                          input logic [1:0] se, input logic [4:0] d, input logic w,
                          input logic [1:0] op, input logic eb, input logic iw,
                          input logic dw);
        d_valid  = dv;
        rs       = {r1, r0};
        src_en   = se;
        rd       = d;
        wr       = w;
        op_class = op;
        ebranch  = eb;
        i_wait   = iw;
        d_wait   = dw;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 2'b00, 0, 0, 2'd0, 0, 0, 0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        idle();
        reset = 1'b1;

        //          dv r1 r0 se     d  w  op eb iw dw ctrl   mb pend
        tbl[0]  = '{0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 8'h00, 0, 32'h0};
        tbl[1]  = '{0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 8'h80, 0, 32'h0};
        tbl[2]  = '{0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 8'hF1, 0, 32'h0};
        tbl[3]  = '{0, 0, 0, 2'b00, 0, 0, 0, 1, 1, 0, 8'hA4, 0, 32'h0};
        tbl[4]  = '{0, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0, 8'h0C, 0, 32'h0};
        tbl[5]  = '{1, 0, 0, 2'b00, 5, 1, 2, 0, 0, 0, 8'h00, 0, 32'h0};
        tbl[6]  = '{1, 0, 1, 2'b01, 6, 1, 1, 0, 0, 0, 8'h00, 0, 32'h20};
        tbl[7]  = '{1, 0, 5, 2'b01, 8, 1, 1, 0, 0, 0, 8'hC2, 0, 32'h60};
        tbl[8]  = '{1, 0, 5, 2'b01, 8, 1, 1, 0, 0, 0, 8'h00, 0, 32'h0};
        tbl[9]  = '{0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 8'h00, 0, 32'h100};
        tbl[10] = '{1, 0, 0, 2'b00, 5, 1, 2, 0, 0, 0, 8'h00, 0, 32'h0};
        tbl[11] = '{1, 0, 5, 2'b01, 10, 1, 1, 1, 0, 0, 8'h0C, 0, 32'h20};
        tbl[12] = '{1, 0, 5, 2'b01, 10, 1, 1, 0, 1, 0, 8'hC2, 0, 32'h20};
        tbl[13] = '{1, 0, 0, 2'b00, 5, 1, 2, 0, 0, 0, 8'h00, 0, 32'h0};
        tbl[14] = '{0, 0, 0, 2'b00, 0, 0, 0, 1, 1, 0, 8'hA4, 0, 32'h20};
        tbl[15] = '{0, 0, 0, 2'b00, 0, 0, 0, 1, 1, 0, 8'hA4, 0, 32'h20};
        tbl[16] = '{1, 5, 0, 2'b10, 8, 1, 1, 0, 0, 0, 8'hC2, 0, 32'h20};
        tbl[17] = '{1, 5, 0, 2'b10, 8, 1, 1, 0, 0, 0, 8'hC2, 0, 32'h20};
        tbl[18] = '{1, 5, 0, 2'b10, 8, 1, 1, 0, 0, 0, 8'h00, 0, 32'h0};
        tbl[19] = '{0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 8'h00, 0, 32'h100};

        tick();
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            set_in(tbl[i].dv, tbl[i].r1, tbl[i].r0, tbl[i].se, tbl[i].d, tbl[i].w,
                   tbl[i].op, tbl[i].eb, tbl[i].iw, tbl[i].dw);
            #1;
            chk($sformatf("vec%0d_ctrl", i), {24'h0, ctrl}, {24'h0, tbl[i].ctrl});
            chk($sformatf("vec%0d_mul_busy", i), {31'h0, mul_busy}, {31'h0, tbl[i].mb});
            chk($sformatf("vec%0d_pending", i), pending, tbl[i].pend);
            tick();
        end

        // Issue to r0 must not mark anything pending; a source of r0 never hazards.
        set_in(1, 0, 0, 2'b00, 0, 1, 2'd3, 0, 0, 0);
        #1;
        chk("rd0_issue_ctrl", {24'h0, ctrl}, 32'h0);
        tick();
        set_in(1, 0, 0, 2'b11, 0, 0, 2'd0, 0, 0, 0);
        #1;
        chk("rd0_pending", pending, 32'h0);
        chk("rs0_no_haz", {24'h0, ctrl}, 32'h0);
        idle();
        for (int i = 0; i < 4; i++) tick();

        // Structural: two back-to-back multi-cycle ops.
        set_in(1, 0, 0, 2'b00, 3, 1, 2'd3, 0, 0, 0);
        #1;
        chk("mul1_issue", {24'h0, ctrl}, 32'h0);
        tick();
        for (int k = 0; k < 4; k++) begin
            set_in(1, 0, 0, 2'b00, 4, 1, 2'd3, 0, 0, 0);
            #1;
            chk($sformatf("mul2_stall%0d", k), {24'h0, ctrl}, 32'hC2);
            chk($sformatf("mul2_busy%0d", k), {31'h0, mul_busy}, 32'h1);
            tick();
        end
        #1;
        chk("mul2_issue", {24'h0, ctrl}, 32'h0);
        chk("mul2_busy_free", {31'h0, mul_busy}, 32'h0);
        tick();
        idle();
        #1;
        chk("mul2_busy_reload", {31'h0, mul_busy}, 32'h1);
        chk("mul2_pending", pending, 32'h10);
        for (int i = 0; i < 4; i++) tick();
        chk("mul_drained_pend", pending, 32'h0);
        chk("mul_drained_busy", {31'h0, mul_busy}, 32'h0);

        // WAW: ALU write to r7 behind a multi-cycle write to r7.
        set_in(1, 0, 0, 2'b00, 7, 1, 2'd3, 0, 0, 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            set_in(1, 0, 0, 2'b00, 7, 1, 2'd1, 0, 0, 0);
            #1;
            chk($sformatf("waw_stall%0d", k), {24'h0, ctrl}, 32'hC2);
            tick();
        end
        #1;
        chk("waw_issue", {24'h0, ctrl}, 32'h0);
        tick();
        idle();
        #1;
        chk("waw_pend7_alu", {31'h0, pending[7]}, 32'h1);
        tick();
        chk("waw_pend7_done", {31'h0, pending[7]}, 32'h0);
        for (int i = 0; i < 4; i++) tick();

        // Data-wait freeze: counter of r9 must hold at 2 across three frozen cycles.
        set_in(1, 0, 0, 2'b00, 9, 1, 2'd2, 0, 0, 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            set_in(0, 0, 0, 2'b00, 0, 0, 2'd0, 0, 0, 1);
            #1;
            chk($sformatf("dwait_ctrl%0d", k), {24'h0, ctrl}, 32'hF1);
            chk($sformatf("dwait_pend%0d", k), pending, 32'h200);
            tick();
        end
        set_in(1, 0, 9, 2'b01, 0, 0, 2'd0, 0, 0, 0);
        #1;
        chk("dwait_resume_haz2", {24'h0, ctrl}, 32'hC2);
        tick();
        chk("dwait_resume_haz1", {24'h0, ctrl}, 32'hC2);
        tick();
        chk("dwait_resume_clear", {24'h0, ctrl}, 32'h0);
        chk("dwait_pend_clear", pending, 32'h0);
        idle();
        for (int i = 0; i < 4; i++) tick();

        // Asynchronous reset with r2, r5 and the multi-cycle unit in flight.
        set_in(1, 0, 0, 2'b00, 2, 1, 2'd3, 0, 0, 0);
        tick();
        set_in(1, 0, 0, 2'b00, 5, 1, 2'd2, 0, 0, 0);
        tick();
        set_in(1, 0, 5, 2'b01, 0, 0, 2'd0, 0, 0, 0);
        #1;
        chk("pre_reset_pend", pending, 32'h24);
        chk("pre_reset_busy", {31'h0, mul_busy}, 32'h1);
        chk("pre_reset_haz", {24'h0, ctrl}, 32'hC2);
        idle();
        #1;
        reset = 1'b1;
        #1;
        chk("reset_pend", pending, 32'h0);
        chk("reset_busy", {31'h0, mul_busy}, 32'h0);
        chk("reset_ctrl", {24'h0, ctrl}, 32'h0);
        tick();
        reset = 1'b0;
        set_in(1, 5, 2, 2'b11, 0, 0, 2'd0, 0, 0, 0);
        #1;
        chk("post_reset_no_haz", {24'h0, ctrl}, 32'h0);
        chk("post_reset_pend", pending, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
